aes_decrypt_iter: RTL

AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

---
 rtl/aes_decrypt_iter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_iter.sv
// AES-128 iterative decryptor: forward key expansion, then ten inverse rounds with on-the-fly inverse key schedule.
// Latency: 21 edges from accept to done (11 on a key-cache hit); one block per 23 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored otherwise. Optional key cache: AES_DEC_KEY_CACHE_EN.
module aes_decrypt_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] ciphertext,
    input  logic [0:127] key,
    output logic [0:127] plaintext,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d, rk_q, rk_d, pt_q, pt_d;
    logic [127:0] ct_in, key_in, rk_fwd, rk_prev, rnd_sub, rnd_out;
    logic         ck_hit;
    logic [127:0] ck_rk;

    // Internally byte n lives at bits [127-8n -: 8]; the [0:127] ports map MSB-first onto this.
    assign ct_in     = ciphertext;
    assign key_in    = key;
    assign plaintext = pt_q;
    assign busy      = (state_q == KEYEXP) || (state_q == ADDKEY) || (state_q == ROUND);
    assign done      = (state_q == DONE);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] aa, bb, p;
        aa = a; bb = b; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01; p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] x);
        return ginv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;
            4'd3: return 8'h08;  4'd4: return 8'h10;  4'd5: return 8'h20;
            4'd6: return 8'h40;  4'd7: return 8'h80;  4'd8: return 8'h1b;
            4'd9: return 8'h36;  default: return 8'h00;
        endcase
    endfunction

    // Round key i -> i+1, using rcon[i].
    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(i), 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Round key i+1 -> i: undo the chained XORs first, then recover word 0.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] i);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rcon(i), 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    // InvShiftRows followed by InvSubBytes: row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = isbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Datapath: next forward key, previous round key, and one inverse round (no mix on round 0).
    assign rk_fwd  = key_fwd(rk_q, cnt_q);
    assign rk_prev = key_inv(rk_q, cnt_q);
    assign rnd_sub = inv_shift_sub(st_q) ^ rk_prev;
    assign rnd_out = (cnt_q == 4'd0) ? rnd_sub : inv_mix(rnd_sub);

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] ck_key_q, ck_key_d, ck_rk_q, ck_rk_d;
    logic         ck_vld_q, ck_vld_d;

    assign ck_hit = ck_vld_q && (key_in == ck_key_q);
    assign ck_rk  = ck_rk_q;

    // Cache refresh: capture the key on a miss, mark valid once its last round key is known.
    always_comb begin
        ck_key_d = ck_key_q;
        ck_rk_d  = ck_rk_q;
        ck_vld_d = ck_vld_q;
        if (state_q == IDLE && start && !ck_hit) begin
            ck_key_d = key_in;
            ck_vld_d = 1'b0;
        end
        if (state_q == KEYEXP && cnt_q == 4'd9) begin
            ck_rk_d  = rk_fwd;
            ck_vld_d = 1'b1;
        end
    end

    // Cache registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ck_key_q <= '0;
            ck_rk_q  <= '0;
            ck_vld_q <= 1'b0;
        end else begin
            ck_key_q <= ck_key_d;
            ck_rk_q  <= ck_rk_d;
            ck_vld_q <= ck_vld_d;
        end
    end
`else
    assign ck_hit = 1'b0;
    assign ck_rk  = '0;
`endif

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        rk_d    = rk_q;
        pt_d    = pt_q;
        case (state_q)
            IDLE: if (start) begin
                st_d  = ct_in;
                cnt_d = 4'd0;
                if (ck_hit) begin
                    rk_d    = ck_rk;
                    cnt_d   = 4'd9;
                    state_d = ADDKEY;
                end else begin
                    rk_d    = key_in;
                    state_d = KEYEXP;
                end
            end
            KEYEXP: begin
                rk_d = rk_fwd;
                if (cnt_q == 4'd9) state_d = ADDKEY;
                else               cnt_d   = cnt_q + 4'd1;
            end
            ADDKEY: begin
                st_d    = st_q ^ rk_q;
                state_d = ROUND;
            end
            ROUND: begin
                rk_d = rk_prev;
                st_d = rnd_out;
                if (cnt_q == 4'd0) begin
                    pt_d    = rnd_out;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            st_q    <= '0;
            rk_q    <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            pt_q    <= pt_d;
        end
    end
endmodule
